// File: rtl/regalu_engine.sv
// Single-clock register file + ALU engine. One operation per start pulse,
// sequenced through read, execute and write-back states with a busy/done handshake.
module regalu_engine #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int SH_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] R_Addr_A,
  input  logic [ADDR_W-1:0] R_Addr_B,
  input  logic [ADDR_W-1:0] W_Addr,
  input  logic [3:0]        ALU_OP,
  input  logic              Reg_Write,
  input  logic              imm_sel,
  input  logic [DATA_W-1:0] imm_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] F,
  output logic [3:0]        FR,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NREGS = 2 ** ADDR_W;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] regs [NREGS];

  logic [ADDR_W-1:0] addr_a_q, addr_b_q, w_addr_q;
  logic [3:0]        op_q;
  logic              reg_write_q, imm_sel_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] op_a, op_b;

  logic [DATA_W-1:0] rd_a, rd_b;
  logic [DATA_W-1:0] alu_res;
  logic              alu_cf, alu_of;
  logic [DATA_W:0]   add_full, sub_full;
  logic [SH_W-1:0]   shamt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = READ;
      READ:    state_next = EXEC;
      EXEC:    state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // busy/done are registered from the next state so they line up with the FSM exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state_next == WB);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      w_addr_q    <= '0;
      op_q        <= '0;
      reg_write_q <= 1'b0;
      imm_sel_q   <= 1'b0;
      imm_q       <= '0;
    end else if (state == IDLE && start) begin
      addr_a_q    <= R_Addr_A;
      addr_b_q    <= R_Addr_B;
      w_addr_q    <= W_Addr;
      op_q        <= ALU_OP;
      reg_write_q <= Reg_Write;
      imm_sel_q   <= imm_sel;
      imm_q       <= imm_data;
    end
  end

  // Register 0 is forced to zero on every read path
  assign rd_a = (addr_a_q == '0) ? '0 : regs[addr_a_q];
  assign rd_b = (addr_b_q == '0) ? '0 : regs[addr_b_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a <= '0;
      op_b <= '0;
    end else if (state == READ) begin
      op_a <= rd_a;
      op_b <= imm_sel_q ? imm_q : rd_b;
    end
  end

  assign add_full = {1'b0, op_a} + {1'b0, op_b};
  assign sub_full = {1'b0, op_a} - {1'b0, op_b};
  assign shamt    = op_b[SH_W-1:0];

  always_comb begin
    alu_res = '0;
    alu_cf  = 1'b0;
    alu_of  = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = add_full[DATA_W-1:0];
        alu_cf  = add_full[DATA_W];
        alu_of  = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                  (add_full[DATA_W-1] != op_a[DATA_W-1]);
      end
      OP_SUB: begin
        alu_res = sub_full[DATA_W-1:0];
        alu_cf  = sub_full[DATA_W];
        alu_of  = (op_a[DATA_W-1] != op_b[DATA_W-1]) &&
                  (sub_full[DATA_W-1] != op_a[DATA_W-1]);
      end
      OP_SLL:  alu_res = op_a << shamt;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
      OP_SLT:  alu_res[0] = ($signed(op_a) < $signed(op_b));
      OP_SLTU: alu_res[0] = (op_a < op_b);
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_AND:  alu_res = op_a & op_b;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      F  <= '0;
      FR <= '0;
    end else if (state == EXEC) begin
      F  <= alu_res;
      FR <= {(alu_res == '0), alu_cf, alu_of, alu_res[DATA_W-1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (state == WB && reg_write_q && w_addr_q != '0) begin
      regs[w_addr_q] <= F;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                dbg_data <= '0;
    else if (dbg_addr == '0)   dbg_data <= '0;
    else                       dbg_data <= regs[dbg_addr];
  end

endmodule
